// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal NIC: packet width, virtual-channel bit and
// the processor-visible register map.
package cardinal_nic_pkg;

   localparam int unsigned DATA_WIDTH = 64;
   localparam int unsigned VC_BIT     = DATA_WIDTH - 1;

   localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
   localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
   localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
   localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

endpackage

// File: rtl/cardinal_nic_if.sv
// Processor register bus plus router handshake of the cardinal NIC.
interface cardinal_nic_if #(
   parameter int unsigned DATA_WIDTH = 64
);

   logic [1:0]            addr;
   logic [DATA_WIDTH-1:0] d_in;
   logic [DATA_WIDTH-1:0] d_out;
   logic                  nicEn;
   logic                  nicWrEn;
   logic                  net_si;
   logic                  net_ri;
   logic [DATA_WIDTH-1:0] net_di;
   logic                  net_so;
   logic                  net_ro;
   logic [DATA_WIDTH-1:0] net_do;
   logic                  net_polarity;

   modport nic (
      input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
      output d_out, net_ri, net_so, net_do
   );

   modport env (
      output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
      input  d_out, net_ri, net_so, net_do
   );

endinterface

// File: rtl/nic_channel_buf.sv
// One-entry packet buffer with full flag. Load wins over clear so a packet
// arriving alongside a read of an empty buffer is not lost.
module nic_channel_buf #(
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic                  clear_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  full_o
);

   logic [DATA_WIDTH-1:0] data_d, data_q;
   logic                  full_d, full_q;

   always_comb begin
      data_d = data_q;
      full_d = full_q;
      if (load_i) begin
         data_d = data_i;
         full_d = 1'b1;
      end else if (clear_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
      end
   end

   assign data_o = data_q;
   assign full_o = full_q;

endmodule

// File: rtl/cardinal_nic.sv
// Network interface between a processor register port and a router PE port,
// with one-entry input and output channels and VC/polarity-gated sends.
module cardinal_nic
   import cardinal_nic_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = cardinal_nic_pkg::DATA_WIDTH
) (
   input logic         clk,
   input logic         rst,
   cardinal_nic_if.nic bus
);

   localparam int unsigned VcBit = DATA_WIDTH - 1;

   logic                  rd_en, wr_en;
   logic                  in_load, in_clear, in_full;
   logic                  out_load, out_full, send;
   logic [DATA_WIDTH-1:0] in_data, out_data;
   logic [DATA_WIDTH-1:0] d_out_d, d_out_q;

   assign rd_en = bus.nicEn & ~bus.nicWrEn;
   assign wr_en = bus.nicEn & bus.nicWrEn;

   assign in_load  = bus.net_si & ~in_full;
   assign in_clear = rd_en & (bus.addr == ADDR_IN_BUF);
   // A write while full (including a send cycle) is dropped.
   assign out_load = wr_en & (bus.addr == ADDR_OUT_BUF) & ~out_full;
   assign send     = out_full & bus.net_ro & (out_data[VcBit] == bus.net_polarity);

   nic_channel_buf #(.DATA_WIDTH(DATA_WIDTH)) u_in_buf (
      .clk     (clk),
      .rst     (rst),
      .load_i  (in_load),
      .clear_i (in_clear),
      .data_i  (bus.net_di),
      .data_o  (in_data),
      .full_o  (in_full)
   );

   nic_channel_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out_buf (
      .clk     (clk),
      .rst     (rst),
      .load_i  (out_load),
      .clear_i (send),
      .data_i  (bus.d_in),
      .data_o  (out_data),
      .full_o  (out_full)
   );

   always_comb begin
      d_out_d = d_out_q;
      if (rd_en) begin
         unique case (bus.addr)
            ADDR_IN_BUF:   d_out_d = in_data;
            ADDR_IN_STAT:  d_out_d = {{(DATA_WIDTH-1){1'b0}}, in_full};
            ADDR_OUT_BUF:  d_out_d = '0;
            ADDR_OUT_STAT: d_out_d = {{(DATA_WIDTH-1){1'b0}}, out_full};
            default:       d_out_d = d_out_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d_out_q <= '0;
      end else begin
         d_out_q <= d_out_d;
      end
   end

   assign bus.d_out  = d_out_q;
   assign bus.net_ri = ~in_full;
   assign bus.net_so = send;
   assign bus.net_do = out_data;

endmodule

// File: tb/tb_cardinal_nic.sv
// Table-driven bench for cardinal_nic; read data is checked through a scoreboard
// queue filled when the read is issued and drained after the capturing edge.
module tb_cardinal_nic;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   cardinal_nic_if #(.DATA_WIDTH(64)) bus ();

   cardinal_nic #(.DATA_WIDTH(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  addr;
      logic        en;
      logic        wr;
      logic [63:0] din;
      logic        si;
      logic [63:0] di;
      logic        ro;
      logic        pol;
      logic        exp_ri;
      logic        exp_so;
      logic        chk_do;
      logic [63:0] exp_do;
      logic        chk_dout;
      logic [63:0] exp_dout;
   } vec_t;

   logic [63:0] sb[$];

   function automatic vec_t mk(logic [1:0] a, logic en, logic wr, logic [63:0] din,
                               logic si, logic [63:0] di, logic ro, logic pol,
                               logic eri, logic eso, logic cdo, logic [63:0] edo,
                               logic cq, logic [63:0] edq);
      vec_t t;
      t.addr = a;    t.en = en;       t.wr = wr;        t.din = din;
      t.si = si;     t.di = di;       t.ro = ro;        t.pol = pol;
      t.exp_ri = eri; t.exp_so = eso; t.chk_do = cdo;   t.exp_do = edo;
      t.chk_dout = cq; t.exp_dout = edq;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t t, input logic r, input string tag);
      logic [63:0] e;
      @(negedge clk);
      rst = r;
      bus.addr = t.addr;  bus.nicEn = t.en;  bus.nicWrEn = t.wr;  bus.d_in = t.din;
      bus.net_si = t.si;  bus.net_di = t.di; bus.net_ro = t.ro;   bus.net_polarity = t.pol;
      #1;
      chk({tag, " net_ri"}, {63'd0, bus.net_ri}, {63'd0, t.exp_ri});
      chk({tag, " net_so"}, {63'd0, bus.net_so}, {63'd0, t.exp_so});
      if (t.chk_do) chk({tag, " net_do"}, bus.net_do, t.exp_do);
      if (t.chk_dout) sb.push_back(t.exp_dout);
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, " d_out"}, bus.d_out, e);
      end
   endtask

   localparam logic [63:0] BEEF = 64'h0000_0000_DEAD_BEEF;
   localparam logic [63:0] PKT1 = 64'h8000_0000_0000_0001;
   localparam logic [63:0] PKT2 = 64'h0000_0000_0000_0042;
   localparam logic [63:0] PKT3 = 64'h8000_0000_0000_00F0;

   vec_t vecs[24];
   vec_t rvecs[7];

   initial begin
      // a, en, wr, din, si, di, ro, pol, eri, eso, cdo, edo, cq, edq
      vecs[0]  = mk(2'b00, 0, 0, 0,     0, 0,    0, 0, 1, 0, 0, 0,    1, 0);
      vecs[1]  = mk(2'b01, 1, 0, 0,     0, 0,    0, 0, 1, 0, 0, 0,    1, 0);
      vecs[2]  = mk(2'b11, 1, 0, 0,     0, 0,    0, 0, 1, 0, 0, 0,    1, 0);
      vecs[3]  = mk(2'b00, 1, 0, 0,     0, 0,    0, 0, 1, 0, 0, 0,    1, 0);
      vecs[4]  = mk(2'b00, 0, 0, 0,     1, BEEF, 0, 0, 1, 0, 0, 0,    0, 0);
      vecs[5]  = mk(2'b00, 0, 0, 0,     0, 0,    0, 0, 0, 0, 0, 0,    0, 0);
      vecs[6]  = mk(2'b01, 1, 0, 0,     0, 0,    0, 0, 0, 0, 0, 0,    1, 1);
      vecs[7]  = mk(2'b00, 1, 0, 0,     0, 0,    0, 0, 0, 0, 0, 0,    1, BEEF);
      vecs[8]  = mk(2'b01, 1, 0, 0,     0, 0,    0, 0, 1, 0, 0, 0,    1, 0);
      vecs[9]  = mk(2'b00, 1, 0, 0,     0, 0,    0, 0, 1, 0, 0, 0,    1, BEEF);
      vecs[10] = mk(2'b10, 1, 1, PKT1,  0, 0,    1, 0, 1, 0, 0, 0,    1, BEEF);
      vecs[11] = mk(2'b10, 1, 1, 64'h5, 0, 0,    1, 0, 1, 0, 1, PKT1, 1, BEEF);
      vecs[12] = mk(2'b11, 1, 0, 0,     0, 0,    1, 0, 1, 0, 0, 0,    1, 1);
      vecs[13] = mk(2'b10, 1, 1, 64'h7, 0, 0,    1, 1, 1, 1, 1, PKT1, 1, 1);
      vecs[14] = mk(2'b11, 1, 0, 0,     0, 0,    1, 1, 1, 0, 1, PKT1, 1, 0);
      vecs[15] = mk(2'b10, 1, 0, 0,     0, 0,    1, 1, 1, 0, 0, 0,    1, 0);
      vecs[16] = mk(2'b10, 1, 1, PKT2,  0, 0,    0, 0, 1, 0, 0, 0,    1, 0);
      vecs[17] = mk(2'b00, 0, 0, 0,     0, 0,    0, 0, 1, 0, 1, PKT2, 0, 0);
      vecs[18] = mk(2'b00, 0, 0, 0,     0, 0,    0, 0, 1, 0, 0, 0,    0, 0);
      vecs[19] = mk(2'b00, 0, 0, 0,     0, 0,    0, 0, 1, 0, 0, 0,    0, 0);
      vecs[20] = mk(2'b00, 0, 0, 0,     0, 0,    0, 0, 1, 0, 0, 0,    0, 0);
      vecs[21] = mk(2'b00, 0, 0, 0,     0, 0,    1, 1, 1, 0, 0, 0,    0, 0);
      vecs[22] = mk(2'b00, 0, 0, 0,     0, 0,    1, 0, 1, 1, 1, PKT2, 0, 0);
      vecs[23] = mk(2'b11, 1, 0, 0,     0, 0,    1, 0, 1, 0, 0, 0,    1, 0);

      // Fill both channels, then reset with traffic present in the reset cycle.
      rvecs[0] = mk(2'b10, 1, 1, PKT3,  1, 64'hAAAA, 0, 0, 1, 0, 0, 0,  1, 0);
      rvecs[1] = mk(2'b11, 1, 0, 0,     0, 0,        1, 0, 0, 0, 1, PKT3, 1, 1);
      rvecs[2] = mk(2'b10, 1, 1, 64'h9, 1, 64'h1234, 1, 1, 0, 1, 0, 0,  1, 0);
      rvecs[3] = mk(2'b00, 0, 0, 0,     0, 0,        1, 1, 1, 0, 1, 0,  0, 0);
      rvecs[4] = mk(2'b01, 1, 0, 0,     0, 0,        1, 1, 1, 0, 0, 0,  1, 0);
      rvecs[5] = mk(2'b11, 1, 0, 0,     0, 0,        1, 1, 1, 0, 0, 0,  1, 0);
      rvecs[6] = mk(2'b00, 1, 0, 0,     0, 0,        1, 1, 1, 0, 0, 0,  1, 0);

      bus.addr = 2'b00; bus.nicEn = 1'b0; bus.nicWrEn = 1'b0; bus.d_in = '0;
      bus.net_si = 1'b0; bus.net_di = '0; bus.net_ro = 1'b0; bus.net_polarity = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset d_out", bus.d_out, 64'd0);
      chk("reset net_ri", {63'd0, bus.net_ri}, 64'd1);
      chk("reset net_so", {63'd0, bus.net_so}, 64'd0);

      for (int i = 0; i < 24; i++) apply(vecs[i], 1'b0, $sformatf("vec%0d", i));
      for (int i = 0; i < 7; i++) apply(rvecs[i], (i == 2), $sformatf("rst%0d", i));

      chk("scoreboard drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
